kws_requant_pipe: RTL

- Pipelined output requantizer that consumes raw int32 convolution accumulators produced by the KWS MAC CFU.
- Per element: adds bias, applies fixed-point multiplier (SRDHM), applies rounding divide by power of two, adds output offset, clamps to the activation range.
- Packs four int8 results into one 32-bit word for write-back.
- Sits directly downstream of the MAC; replaces per-element CPU calls to the SRDHM/RCDBPOT ops with a streaming engine.

---
 rtl/kws_requant_pipe.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/kws_requant_pipe.sv
// Streaming requantizer for KWS MAC accumulators. It applies bias, SRDHM, a rounding shift,
// an output offset and an activation clamp, then packs four int8 results into each 32-bit word.
module kws_requant_pipe #(
  parameter int LANES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_sel,
  input  logic [31:0] cfg_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_acc,
  input  logic        flush_valid,
  output logic        flush_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_lanes
);

  localparam logic [2:0] LANES_C = 3'(LANES);

  logic signed [31:0] bias_r, mult_r, out_offset_r, act_min_r, act_max_r;
  logic [4:0]         shift_r;
  logic               v1_r, v2_r, v3_r;
  logic signed [31:0] x_r, y_r;
  logic [7:0]         b3_r;
  logic [2:0]         count_r;
  logic [7:0]         lane_r [0:3];
  logic               out_valid_r;
  logic [31:0]        out_data_r;
  logic [2:0]         out_lanes_r;

  logic               stall_s, empty_s, pack_s, flush_fire_s, cfg_fire_s;
  logic signed [63:0] prod_s, nudge_s, sum_s;
  logic signed [31:0] y_s;
  logic [31:0]        mask_s, rem_s, thr_s;
  logic signed [31:0] z_s, w_s;
  logic [7:0]         clamp_s;
  logic [31:0]        full_word_s, flush_word_s, load_data_s;
  logic               load_s;
  logic [2:0]         load_lanes_s;

  assign stall_s      = out_valid_r & ~out_ready;
  assign empty_s      = ~v1_r & ~v2_r & ~v3_r;
  assign in_ready     = ~stall_s;
  assign cfg_ready    = empty_s & ~in_valid;
  assign flush_ready  = ~stall_s & empty_s & ~in_valid;
  assign cfg_fire_s   = cfg_valid & cfg_ready;
  assign flush_fire_s = flush_valid & flush_ready;
  assign pack_s       = v3_r & ~stall_s;

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_lanes = out_lanes_r;

  // Configuration registers; writes only land while the pipeline is empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bias_r       <= 32'sd0;
      mult_r       <= 32'sh40000000;
      shift_r      <= 5'd0;
      out_offset_r <= 32'sd0;
      act_min_r    <= -32'sd128;
      act_max_r    <= 32'sd127;
    end else if (cfg_fire_s) begin
      case (cfg_sel)
        3'd0:    bias_r       <= cfg_data;
        3'd1:    mult_r       <= cfg_data;
        3'd2:    shift_r      <= cfg_data[4:0];
        3'd3:    out_offset_r <= cfg_data;
        3'd4:    act_min_r    <= cfg_data;
        3'd5:    act_max_r    <= cfg_data;
        default: ;
      endcase
    end
  end

  // S1: bias add
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_r <= 1'b0;
      x_r  <= 32'sd0;
    end else if (!stall_s) begin
      v1_r <= in_valid;
      x_r  <= in_acc + bias_r;
    end
  end

  // SRDHM: the low 32 bits of (sum >>> 31) are sum[62:31]; negative sums round back toward zero
  always_comb begin
    prod_s  = {{32{x_r[31]}}, x_r} * {{32{mult_r[31]}}, mult_r};
    nudge_s = prod_s[63] ? 64'shFFFFFFFFC0000001 : 64'sh0000000040000000;
    sum_s   = prod_s + nudge_s;
    if ((x_r == 32'sh80000000) && (mult_r == 32'sh80000000)) begin
      y_s = 32'sh7FFFFFFF;
    end else if (sum_s[63] && (sum_s[30:0] != 31'd0)) begin
      y_s = sum_s[62:31] + 32'sd1;
    end else begin
      y_s = sum_s[62:31];
    end
  end

  // S2: fixed-point multiply result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2_r <= 1'b0;
      y_r  <= 32'sd0;
    end else if (!stall_s) begin
      v2_r <= v1_r;
      y_r  <= y_s;
    end
  end

  // Rounding shift, offset and clamp; an inverted range collapses to act_max
  always_comb begin
    mask_s = (32'd1 << shift_r) - 32'd1;
    rem_s  = y_r & mask_s;
    thr_s  = (mask_s >> 1) + {31'd0, y_r[31]};
    z_s    = (y_r >>> shift_r) + ((rem_s > thr_s) ? 32'sd1 : 32'sd0);
    w_s    = z_s + out_offset_r;
    if (act_min_r > act_max_r) begin
      clamp_s = act_max_r[7:0];
    end else if (w_s < act_min_r) begin
      clamp_s = act_min_r[7:0];
    end else if (w_s > act_max_r) begin
      clamp_s = act_max_r[7:0];
    end else begin
      clamp_s = w_s[7:0];
    end
  end

  // S3: int8 result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v3_r <= 1'b0;
      b3_r <= 8'd0;
    end else if (!stall_s) begin
      v3_r <= v2_r;
      b3_r <= clamp_s;
    end
  end

  // Word assembly for a completed word or a flushed partial word
  always_comb begin
    full_word_s  = {b3_r, lane_r[2], lane_r[1], lane_r[0]};
    flush_word_s = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < count_r) begin
        flush_word_s[8*i +: 8] = lane_r[i];
      end else begin
        flush_word_s[8*i +: 8] = 8'd0;
      end
    end
    if (pack_s && (count_r == (LANES_C - 3'd1))) begin
      load_s       = 1'b1;
      load_data_s  = full_word_s;
      load_lanes_s = LANES_C;
    end else if (flush_fire_s && (count_r != 3'd0)) begin
      load_s       = 1'b1;
      load_data_s  = flush_word_s;
      load_lanes_s = count_r;
    end else begin
      load_s       = 1'b0;
      load_data_s  = out_data_r;
      load_lanes_s = out_lanes_r;
    end
  end

  // Packer lane storage and fill count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= 3'd0;
      for (int i = 0; i < 4; i++) lane_r[i] <= 8'd0;
    end else if (pack_s) begin
      lane_r[count_r[1:0]] <= b3_r;
      count_r <= (count_r == (LANES_C - 3'd1)) ? 3'd0 : count_r + 3'd1;
    end else if (flush_fire_s) begin
      count_r <= 3'd0;
    end
  end

  // Output word register; a new word may replace one being handshaken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 32'd0;
      out_lanes_r <= 3'd0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= load_data_s;
      out_lanes_r <= load_lanes_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule
